// File: rtl/match_collector.sv
// match_collector: sequences one run of the pattern-search stage, captures
// each distinct match address into a small FIFO, and lets a downstream stage
// pop addresses with a read handshake. Also reports the match count, a sticky
// overflow flag and a sticky watchdog timeout.
module match_collector #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CLR_CYCLES     = 2
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] found_in,
  input  logic       done_in,
  output logic       search_reset,
  output logic       search_activate,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       empty,
  output logic       full,
  output logic [7:0] match_count,
  output logic       overflow,
  output logic       busy,
  output logic       finished,
  output logic       timeout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLR, ST_RUN, ST_FLUSH, ST_FINISHED
  } state_t;

  state_t            state_r, state_next_s;
  logic [CLR_W-1:0]  clr_cnt_r;
  logic [WD_W-1:0]   wd_r;
  logic [7:0]        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r, count_next_s;
  logic [7:0]        prev_found_r;
  logic [7:0]        rd_data_r, match_count_r;
  logic              rd_valid_r, empty_r, full_r, overflow_r, timeout_r;
  logic              search_reset_r, activate_r, busy_r, finished_r;
  logic              flush_s, timeout_hit_s, capture_s, match_s;
  logic              pop_s, push_s, drop_s;

  // Next-state logic; a start from IDLE/FINISHED also requests a FIFO flush.
  always_comb begin
    state_next_s  = state_r;
    flush_s       = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FINISHED: begin
        if (start) begin
          state_next_s = ST_CLR;
          flush_s      = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_CLR: begin
        if (clr_cnt_r == CLR_W'(CLR_CYCLES - 1)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLR;
        end
      end
      ST_RUN: begin
        if (done_in) begin
          state_next_s = ST_FLUSH;
        end else if (wd_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_next_s  = ST_FINISHED;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FLUSH: state_next_s = ST_FINISHED;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Match detection and FIFO push/pop decisions; a full FIFO still accepts a
  // push when a pop frees a slot in the same cycle.
  always_comb begin
    capture_s = (state_r == ST_RUN) || (state_r == ST_FLUSH);
    match_s   = capture_s && (found_in != prev_found_r) && (found_in != 8'hFF);
    pop_s     = rd_en && (count_r != CW'(0)) && !flush_s;
    push_s    = match_s && ((count_r != CW'(DEPTH)) || pop_s);
    drop_s    = match_s && !push_s;
    if (flush_s) begin
      count_next_s = CW'(0);
    end else if (push_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // State register plus the CLR-phase counter and RUN watchdog.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= '0;
      wd_r      <= '0;
    end else begin
      state_r <= state_next_s;
      if (flush_s) begin
        clr_cnt_r <= '0;
        wd_r      <= '0;
      end else begin
        if (state_r == ST_CLR) clr_cnt_r <= clr_cnt_r + CLR_W'(1);
        if (state_r == ST_RUN) wd_r <= wd_r + WD_W'(1);
      end
    end
  end

  // FIFO storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge CLK100MHZ) begin
    if (push_s) mem_r[wr_ptr_r] <= found_in;
  end

  // FIFO pointers, occupancy, registered read port and empty/full flags.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
    end else begin
      count_r    <= count_next_s;
      empty_r    <= (count_next_s == CW'(0));
      full_r     <= (count_next_s == CW'(DEPTH));
      rd_valid_r <= pop_s;
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s) begin
          rd_ptr_r  <= rd_ptr_r + AW'(1);
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
    end
  end

  // Per-run capture bookkeeping: last found value, match count, sticky flags.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      prev_found_r  <= 8'hFF;
      match_count_r <= 8'h00;
      overflow_r    <= 1'b0;
      timeout_r     <= 1'b0;
    end else if (flush_s) begin
      prev_found_r  <= 8'hFF;
      match_count_r <= 8'h00;
      overflow_r    <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      if (capture_s) prev_found_r <= found_in;
      if (match_s && (match_count_r != 8'hFF)) match_count_r <= match_count_r + 8'd1;
      if (drop_s) overflow_r <= 1'b1;
      if (timeout_hit_s) timeout_r <= 1'b1;
    end
  end

  // Status/control outputs registered from the next state so they align with it.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      search_reset_r <= 1'b0;
      activate_r     <= 1'b0;
      busy_r         <= 1'b0;
      finished_r     <= 1'b0;
    end else begin
      search_reset_r <= (state_next_s == ST_CLR);
      activate_r     <= (state_next_s == ST_RUN) || (state_next_s == ST_FLUSH);
      busy_r         <= (state_next_s == ST_CLR) || (state_next_s == ST_RUN) ||
                        (state_next_s == ST_FLUSH);
      finished_r     <= (state_next_s == ST_FINISHED);
    end
  end

  // The search stage must be held in reset whenever this block is in reset.
  assign search_reset    = search_reset_r | reset;
  assign search_activate = activate_r;
  assign rd_data         = rd_data_r;
  assign rd_valid        = rd_valid_r;
  assign empty           = empty_r;
  assign full            = full_r;
  assign match_count     = match_count_r;
  assign overflow        = overflow_r;
  assign busy            = busy_r;
  assign finished        = finished_r;
  assign timeout         = timeout_r;

endmodule

// File: tb/tb_match_collector.sv
// Self-checking bench for match_collector: directed scenarios plus random
// runs, compared every cycle against a queue-based behavioural model.
module tb_match_collector;
  localparam int DEPTH = 16;
  localparam int TO    = 100;
  localparam int CLRC  = 2;
  localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_FLUSH = 3, P_FIN = 4;

  logic       CLK100MHZ = 1'b0;
  logic       reset, start, done_in, rd_en;
  logic [7:0] found_in;
  logic       search_reset, search_activate, rd_valid, empty, full;
  logic       overflow, busy, finished, timeout;
  logic [7:0] rd_data, match_count;

  always #5 CLK100MHZ = ~CLK100MHZ;

  match_collector #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CLR_CYCLES(CLRC)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .found_in(found_in),
    .done_in(done_in), .search_reset(search_reset), .search_activate(search_activate),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .match_count(match_count), .overflow(overflow), .busy(busy), .finished(finished),
    .timeout(timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int act_cycles = 0;
  int srst_cycles = 0;

  // behavioural model
  int         m_phase, m_clr_n, m_run_n, m_count;
  logic [7:0] m_q[$];
  logic [7:0] m_prev, m_rd_data;
  logic       m_rd_valid, m_ovf, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_clr_n = 0; m_run_n = 0; m_count = 0;
    m_q.delete(); m_prev = 8'hFF; m_rd_data = 8'h00;
    m_rd_valid = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
  endfunction

  function automatic void model_step(input logic st, input logic [7:0] f,
                                     input logic dn, input logic rd);
    logic capt, mt, pp, fl;
    capt = (m_phase == P_RUN) || (m_phase == P_FLUSH);
    mt   = capt && (f != m_prev) && (f != 8'hFF);
    pp   = rd && (m_q.size() > 0);
    fl   = st && ((m_phase == P_IDLE) || (m_phase == P_FIN));
    if (fl) begin
      m_q.delete(); m_rd_valid = 1'b0; m_count = 0; m_ovf = 1'b0; m_to = 1'b0;
      m_prev = 8'hFF; m_phase = P_CLR; m_clr_n = 0; m_run_n = 0;
      return;
    end
    m_rd_valid = pp;
    if (pp) m_rd_data = m_q.pop_front();
    if (mt) begin
      if (m_count < 255) m_count++;
      if (m_q.size() < DEPTH) m_q.push_back(f);
      else m_ovf = 1'b1;
    end
    if (capt) m_prev = f;
    case (m_phase)
      P_CLR: begin
        m_clr_n++;
        if (m_clr_n == CLRC) m_phase = P_RUN;
      end
      P_RUN: begin
        m_run_n++;
        if (dn) m_phase = P_FLUSH;
        else if (m_run_n == TO) begin m_phase = P_FIN; m_to = 1'b1; end
      end
      P_FLUSH: m_phase = P_FIN;
      default: ;
    endcase
  endfunction

  task automatic compare_all();
    check("search_reset", 32'(search_reset), 32'((m_phase == P_CLR) || reset));
    check("search_activate", 32'(search_activate), 32'((m_phase == P_RUN) || (m_phase == P_FLUSH)));
    check("busy", 32'(busy), 32'((m_phase == P_CLR) || (m_phase == P_RUN) || (m_phase == P_FLUSH)));
    check("finished", 32'(finished), 32'(m_phase == P_FIN));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("match_count", 32'(match_count), 32'(m_count));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("timeout", 32'(timeout), 32'(m_to));
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  // One clock: snapshot inputs, step the model at the edge, compare just after.
  task automatic tick();
    logic st, dn, rd;
    logic [7:0] f;
    st = start; dn = done_in; rd = rd_en; f = found_in;
    @(posedge CLK100MHZ);
    if (reset) model_reset();
    else model_step(st, f, dn, rd);
    #1;
    compare_all();
    if (search_activate === 1'b1) act_cycles++;
    if (search_reset === 1'b1) srst_cycles++;
  endtask

  task automatic start_run();
    act_cycles = 0; srst_cycles = 0;
    found_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int i = 0;
    while (search_activate !== 1'b1 && i < 20) begin tick(); i++; end
    check(name, 32'(search_activate), 32'd1);
  endtask

  task automatic wait_fin(input string name);
    int i = 0;
    while (finished !== 1'b1 && i < 300) begin tick(); i++; end
    check(name, 32'(finished), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; done_in = 1'b0; rd_en = 1'b0; found_in = 8'hFF;
    model_reset();
    tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_search_reset", 32'(search_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Run with no matches; done on the 40th RUN cycle.
    start_run();
    wait_run("t1_reach_run");
    repeat (39) tick();
    done_in = 1'b1; tick(); done_in = 1'b0;
    wait_fin("t1_reach_fin");
    check("t1_srst_cycles", 32'(srst_cycles), 32'd2);
    check("t1_act_cycles", 32'(act_cycles), 32'd41);
    check("t1_count", 32'(match_count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

    // FF -> 0A -> 0A -> 23 -> 40 with done on the last change.
    start_run();
    wait_run("t2_reach_run");
    repeat (2) tick();
    found_in = 8'h0A; tick(); tick();
    found_in = 8'h23; tick();
    found_in = 8'h40; done_in = 1'b1; tick(); done_in = 1'b0;
    wait_fin("t2_reach_fin");
    check("t2_count", 32'(match_count), 32'd3);
    rd_en = 1'b1;
    tick(); check("t2_pop0", 32'({rd_valid, rd_data}), 32'h10A);
    tick(); check("t2_pop1", 32'({rd_valid, rd_data}), 32'h123);
    tick(); check("t2_pop2", 32'({rd_valid, rd_data}), 32'h140);
    rd_en = 1'b0; tick();
    check("t2_empty", 32'(empty), 32'd1);

    // Fill exactly, then simultaneous match and pop while full.
    start_run();
    wait_run("t4_reach_run");
    for (int i = 0; i < DEPTH; i++) begin found_in = 8'(8'h80 + i); tick(); end
    check("t4_full", 32'(full), 32'd1);
    check("t4_ovf0", 32'(overflow), 32'd0);
    found_in = 8'hA0; rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t4_simul_pop", 32'({rd_valid, rd_data}), 32'h180);
    check("t4_simul_full", 32'(full), 32'd1);
    check("t4_simul_ovf", 32'(overflow), 32'd0);
    done_in = 1'b1; tick(); done_in = 1'b0;
    wait_fin("t4_reach_fin");
    rd_en = 1'b1;
    repeat (DEPTH) tick();
    tick();
    check("t4_rd_empty_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;

    // Overflow: 18 distinct addresses into a 16-entry FIFO.
    start_run();
    wait_run("t3_reach_run");
    for (int i = 0; i < 18; i++) begin found_in = 8'(i); tick(); end
    done_in = 1'b1; tick(); done_in = 1'b0;
    wait_fin("t3_reach_fin");
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count", 32'(match_count), 32'd18);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("t3_pop", 32'({rd_valid, rd_data}), 32'h100 | 32'(i));
    end
    rd_en = 1'b0; tick();
    check("t3_empty", 32'(empty), 32'd1);

    // Watchdog: done never comes.
    start_run();
    wait_run("t5_reach_run");
    for (int i = 1; i <= 3; i++) begin found_in = 8'(i); tick(); end
    wait_fin("t5_reach_fin");
    check("t5_act_cycles", 32'(act_cycles), 32'd100);
    check("t5_timeout", 32'(timeout), 32'd1);
    check("t5_activate", 32'(search_activate), 32'd0);
    check("t5_not_empty", 32'(empty), 32'd0);
    start_run();
    check("t5_timeout_clr", 32'(timeout), 32'd0);
    check("t5_flushed", 32'(empty), 32'd1);

    // Reset during RUN with five entries queued.
    wait_run("t6_reach_run");
    for (int i = 0; i < 5; i++) begin found_in = 8'(8'h10 + i); tick(); end
    reset = 1'b1; tick();
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_count", 32'(match_count), 32'd0);
    check("t6_srst", 32'(search_reset), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0; found_in = 8'hFF; tick();
    check("t6_srst_rel", 32'(search_reset), 32'd0);
    start_run();
    wait_run("t6b_reach_run");
    found_in = 8'h33; tick();
    done_in = 1'b1; tick(); done_in = 1'b0;
    wait_fin("t6b_reach_fin");
    check("t6b_count", 32'(match_count), 32'd1);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      start_run();
      for (int c = 0; c < 160; c++) begin
        found_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 9));
        rd_en    = ($urandom_range(0, 2) == 0);
        done_in  = ($urandom_range(0, 40) == 0);
        start    = ($urandom_range(0, 20) == 0);
        tick();
      end
      start = 1'b0; done_in = 1'b1; rd_en = 1'b0; tick();
      done_in = 1'b0; tick(); tick();
      rd_en = 1'b1;
      repeat (DEPTH + 2) tick();
      rd_en = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
